// File: rtl/display_spi_master.sv
// MCU-to-display SPI master: 128-bit title or 24-bit note frames, spiDone ack.
// Optional done timeout when DISPLAY_SPI_TIMEOUT_EN is defined.
module display_spi_master #(
  parameter int CLK_DIV = 4
`ifdef DISPLAY_SPI_TIMEOUT_EN
  ,
  parameter int DONE_TIMEOUT = 65535
`endif
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         selTitle,
  input  logic [127:0] titleData,
  input  logic [23:0]  noteData,
  input  logic         spiDone,
  output logic         busy,
  output logic         done,
`ifdef DISPLAY_SPI_TIMEOUT_EN
  output logic         timeout,
`endif
  output logic         sck,
  output logic         sdi,
  output logic         spiLoad,
  output logic         titleNote
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    WAIT_DONE
  } state_t;

  state_t        state;
  logic [DW-1:0] div;
  logic [7:0]    bits;
  logic [127:0]  shift;
  logic          sync1;
  logic          sync2;
  logic          sync_prev;
  logic          ack;
  logic          div_end;

  assign ack     = sync2 & ~sync_prev;
  assign div_end = (div == DIV_LAST);

`ifdef DISPLAY_SPI_TIMEOUT_EN
  localparam logic [15:0] T_LAST = 16'(DONE_TIMEOUT - 1);
  logic [15:0] tcnt;
  logic        expired;
  assign expired = (tcnt == T_LAST);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync1     <= spiDone;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      div       <= '0;
      bits      <= '0;
      shift     <= '0;
      sck       <= 1'b0;
      sdi       <= 1'b0;
      spiLoad   <= 1'b0;
      titleNote <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef DISPLAY_SPI_TIMEOUT_EN
      tcnt      <= '0;
      timeout   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !done) begin
            shift     <= selTitle ? titleData
                                  : {noteData, 104'd0};
            bits      <= selTitle ? 8'd128 : 8'd24;
            sdi       <= selTitle ? titleData[127]
                                  : noteData[23];
            titleNote <= selTitle;
            busy      <= 1'b1;
            spiLoad   <= 1'b1;
            div       <= '0;
            state     <= SETUP;
`ifdef DISPLAY_SPI_TIMEOUT_EN
            timeout   <= 1'b0;
`endif
          end
        end
        SETUP: begin
          div <= div + 1'b1;
          if (div_end) begin
            div   <= '0;
            sck   <= 1'b1;
            state <= HIGH;
          end
        end
        HIGH: begin
          div <= div + 1'b1;
          if (div_end) begin
            div   <= '0;
            bits  <= bits - 8'd1;
            sck   <= 1'b0;
            // rotate keeps every bit live; spare bits never reach sdi
            shift <= {shift[126:0], shift[127]};
            sdi   <= shift[126];
            state <= LOW;
          end
        end
        LOW: begin
          div <= div + 1'b1;
          if (div_end) begin
            div <= '0;
            if (bits != 8'd0) begin
              sck   <= 1'b1;
              state <= HIGH;
            end else begin
              spiLoad <= 1'b0;
              sdi     <= 1'b0;
              state   <= WAIT_DONE;
`ifdef DISPLAY_SPI_TIMEOUT_EN
              tcnt    <= '0;
`endif
            end
          end
        end
        WAIT_DONE: begin
          if (ack) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
`ifdef DISPLAY_SPI_TIMEOUT_EN
          end else if (expired) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            timeout <= 1'b1;
            state   <= IDLE;
          end else begin
            tcnt <= tcnt + 16'd1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_display_spi_master.sv
// Bench for display_spi_master: frame table plus random frames vs bit model.
// Also covers ack handshake, ignored starts, mid-frame reset, timeout.
module tb_display_spi_master;

  localparam int CK = 4;
  localparam int DONE_T = 100;

  logic         clk;
  logic         reset;
  logic         start;
  logic         selTitle;
  logic [127:0] titleData;
  logic [23:0]  noteData;
  logic         spiDone;
  logic         busy;
  logic         done;
  logic         timeout;
  logic         sck;
  logic         sdi;
  logic         spiLoad;
  logic         titleNote;

  int n_chk;
  int n_fail;

  typedef struct {
    logic         sel;
    logic [127:0] title;
    logic [23:0]  note;
    int           mode;
    int           ackd;
    bit           b2b;
    int           exp_edges;
    int           exp_load;
  } vec_t;

  vec_t tab[$];

`ifdef DISPLAY_SPI_TIMEOUT_EN
  display_spi_master #(
    .CLK_DIV(CK),
    .DONE_TIMEOUT(DONE_T)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .selTitle(selTitle), .titleData(titleData),
    .noteData(noteData), .spiDone(spiDone),
    .busy(busy), .done(done), .timeout(timeout),
    .sck(sck), .sdi(sdi), .spiLoad(spiLoad),
    .titleNote(titleNote)
  );
`else
  assign timeout = 1'b0;
  display_spi_master #(
    .CLK_DIV(CK)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .selTitle(selTitle), .titleData(titleData),
    .noteData(noteData), .spiDone(spiDone),
    .busy(busy), .done(done),
    .sck(sck), .sdi(sdi), .spiLoad(spiLoad),
    .titleNote(titleNote)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Frame model: characters in order, each ASCII byte MSB first.
  function automatic int n_chars(input logic sel);
    return sel ? 16 : 3;
  endfunction

  task automatic model_bits(input vec_t v, output bit q[$]);
    logic [7:0] ch;
    q = {};
    for (int c = 0; c < n_chars(v.sel); c++) begin
      if (v.sel) ch = v.title[127 - 8*c -: 8];
      else       ch = v.note[23 - 8*c -: 8];
      for (int b = 7; b >= 0; b--) q.push_back(ch[b]);
    end
  endtask

  task automatic run_frame(input vec_t v, input int idx);
    bit   q[$];
    bit   cap[$];
    int   load, rises, stab, bbad, tnbad, mm;
    int   fall, raise, done_k, age, since, exp_done;
    logic psck, psdi, psl, busy_d, to_d;
    string tag;
    tag = $sformatf("f%0d", idx);
    model_bits(v, q);
    load = 0; rises = 0; stab = 0; bbad = 0; tnbad = 0;
    fall = -1; raise = -1; done_k = -1;
    age = 0; since = 1000;
    busy_d = 1'b1; to_d = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; selTitle = v.sel;
    titleData = v.title; noteData = v.note;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy_acc"}, busy, 1);
    chk({tag, "_tn_acc"}, titleNote, v.sel);
    chk({tag, "_load_acc"}, spiLoad, 1);
`ifdef DISPLAY_SPI_TIMEOUT_EN
    chk({tag, "_to_clr"}, timeout, 0);
`endif
    psck = sck; psdi = sdi; psl = spiLoad;
    for (int k = 0; k < 4000; k++) begin
      since++;
      if (k == 0 || sdi !== psdi) begin
        if (k > 0 && spiLoad && rises > 0 && since < CK)
          stab++;
        age = 0;
      end else begin
        age++;
      end
      if (spiLoad) load++;
      if (sck && !psck) begin
        rises++;
        if (spiLoad) cap.push_back(sdi);
        if (age < CK) stab++;
        since = 0;
      end
      if (titleNote !== v.sel) tnbad++;
      if (psl && !spiLoad && fall < 0) fall = k;
      if (done) begin
        done_k = k; busy_d = busy; to_d = timeout;
        break;
      end
      if (!busy) bbad++;
      if (k == 100 || (fall >= 0 && k == fall + 10)) begin
        start = 1'b1; selTitle = ~v.sel;
        titleData = {4{$urandom()}};
        noteData = 24'($urandom());
      end else begin
        start = 1'b0;
      end
      if (v.mode == 0 && fall >= 0 && k == fall + v.ackd) begin
        spiDone = 1'b1; raise = k;
      end
      if (v.mode == 1) begin
        if (k == 20) spiDone = 1'b1;
        if (fall >= 0 && k == fall + 30) spiDone = 1'b0;
        if (fall >= 0 && k == fall + 34) begin
          spiDone = 1'b1; raise = k;
        end
      end
      psck = sck; psdi = sdi; psl = spiLoad;
      @(posedge clk); #1;
    end
    start = 1'b0;
    spiDone = 1'b0;
    chk({tag, "_done_seen"}, done_k >= 0, 1);
    if (done_k < 0) return;
    exp_done = (v.mode == 2) ? fall + DONE_T : raise + 3;
    mm = 0;
    if (cap.size() != q.size()) mm = 999;
    else foreach (q[i]) if (cap[i] != q[i]) mm++;
    chk({tag, "_edges"}, rises, v.exp_edges);
    chk({tag, "_load_len"}, load, v.exp_load);
    chk({tag, "_bit_err"}, mm, 0);
    chk({tag, "_sdi_stable"}, stab, 0);
    chk({tag, "_busy_held"}, bbad, 0);
    chk({tag, "_tn_held"}, tnbad, 0);
    chk({tag, "_busy_at_done"}, busy_d, 0);
    chk({tag, "_done_lat"}, done_k, exp_done);
`ifdef DISPLAY_SPI_TIMEOUT_EN
    chk({tag, "_timeout"}, to_d, v.mode == 2);
`endif
    if (!v.b2b) begin
      start = 1'b1; selTitle = ~v.sel;
      @(posedge clk); #1;
      start = 1'b0;
      chk({tag, "_done_pulse"}, done, 0);
      chk({tag, "_start_on_done"}, {busy, spiLoad}, 0);
      chk({tag, "_tn_after"}, titleNote, v.sel);
    end
  endtask

  function automatic vec_t mk(input logic sel,
                              input logic [127:0] t,
                              input logic [23:0] n,
                              input int mode, input int ackd,
                              input bit b2b);
    vec_t v;
    v.sel = sel; v.title = t; v.note = n;
    v.mode = mode; v.ackd = ackd; v.b2b = b2b;
    v.exp_edges = 8 * n_chars(sel);
    v.exp_load = CK * (2 * v.exp_edges + 1);
    return v;
  endfunction

  initial begin
    vec_t v;
    int   r, n, dn;
    logic psck;
    n_chk = 0; n_fail = 0;
    reset = 1'b1; start = 1'b0; selTitle = 1'b0;
    titleData = '0; noteData = '0; spiDone = 1'b0;

    v = mk(0, '0, 24'h413420, 0, 50, 0);
    v.exp_edges = 24; v.exp_load = 196;
    tab.push_back(v);
    v = mk(1, "Mary Had A Lamb ", '0, 0, 50, 1);
    v.exp_edges = 128; v.exp_load = 1028;
    tab.push_back(v);
    tab.push_back(mk(0, '0, 24'h5A5AA5, 1, 0, 0));
    tab.push_back(mk(1, 128'hFFFF_0000_8001_7FFE_0102_0408_1020_4080,
                     '0, 0, 20, 0));
    for (int i = 0; i < 4; i++)
      tab.push_back(mk(1'($urandom_range(0, 1)),
                       {4{$urandom()}}, 24'($urandom()), 0,
                       $urandom_range(15, 60),
                       1'($urandom_range(0, 1))));
`ifdef DISPLAY_SPI_TIMEOUT_EN
    tab.push_back(mk(0, '0, 24'h4C4F4E, 2, 0, 0));
    tab.push_back(mk(1, {4{32'h4142_4344}}, '0, 0, 30, 0));
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", {sck, sdi, spiLoad, titleNote, busy, done},
        0);
    chk("rst_timeout", timeout, 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    foreach (tab[i]) run_frame(tab[i], i);

    @(posedge clk); #1;
    start = 1'b1; selTitle = 1'b1;
    titleData = {4{$urandom()}};
    @(posedge clk); #1;
    start = 1'b0;
    r = 0; n = 0; psck = sck;
    while (r < 60 && n < 2000) begin
      @(posedge clk); #1;
      if (sck && !psck) r++;
      psck = sck;
      n++;
    end
    chk("rst_mid_edges", r, 60);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_load", spiLoad, 0);
    chk("rst_mid_sck", sck, 0);
    chk("rst_mid_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    dn = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    chk("rst_mid_no_done", dn, 0);
    run_frame(mk(0, '0, 24'h313233, 0, 25, 0), 99);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
